target_generator: RTL

- Produces the on-screen target coordinate, in 4-pixel grid units, for the snake playfield.
- Sits directly upstream of the snake control/render stage, driving its TARGET_ADDR_H/TARGET_ADDR_V inputs.
- Consumes that stage's TARGET_REACHED output and the master state.
- Uses free-running LFSRs with rejection sampling to choose a new in-range target each time the previous one is eaten.

---
 rtl/target_generator.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/target_generator.sv
// target_generator: picks the snake's next food position in 4-pixel grid units.
// Two free-running LFSRs feed a rejection sampler; a bounded search falls back
// to a deterministic offset so a new target always appears within SEARCH_MAX+1 cycles.
module target_generator #(
  parameter int unsigned MAX_X      = 159,
  parameter int unsigned MAX_Y      = 119,
  parameter int unsigned INIT_X     = 40,
  parameter int unsigned INIT_Y     = 30,
  parameter logic [7:0]  SEED_H     = 8'hA5,
  parameter logic [6:0]  SEED_V     = 7'h5B,
  parameter int unsigned SEARCH_MAX = 63
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] MSM_STATE,
  input  logic       TARGET_REACHED,
  output logic [7:0] TARGET_ADDR_H,
  output logic [6:0] TARGET_ADDR_V,
  output logic       TARGET_VALID,
  output logic       TARGET_UPDATED
);

  typedef enum logic {
    HOLD   = 1'b0,
    SEARCH = 1'b1
  } state_e;

  localparam logic [7:0] INIT_H  = 8'(INIT_X);
  localparam logic [6:0] INIT_V  = 7'(INIT_Y);
  localparam logic [8:0] MAX_H9  = 9'(MAX_X);
  localparam logic [7:0] MAX_V8  = 8'(MAX_Y);
  localparam logic [8:0] LIM_H   = 9'(MAX_X) + 9'd1;
  localparam logic [7:0] LIM_V   = 8'(MAX_Y) + 8'd1;
  localparam logic [5:0] CNT_MAX = 6'(SEARCH_MAX);

  localparam logic [1:0] MSM_IDLE = 2'b00;
  localparam logic [1:0] MSM_PLAY = 2'b01;

  state_e     state_q, state_d;
  logic [7:0] lfsr_h_q, lfsr_h_d;
  logic [6:0] lfsr_v_q, lfsr_v_d;
  logic       reached_q;
  logic [5:0] cnt_q, cnt_d;
  logic [7:0] addr_h_q, addr_h_d;
  logic [6:0] addr_v_q, addr_v_d;
  logic       valid_q, valid_d;
  logic       upd_q, upd_d;

  logic       rise;
  logic       accept;
  logic [8:0] fb_h_sum;
  logic [7:0] fb_v_sum;
  logic [7:0] fb_h;
  logic [6:0] fb_v;

  // LFSR next values; an all-zero state reloads the seed to escape lock-up
  always_comb begin
    lfsr_h_d = {lfsr_h_q[6:0], lfsr_h_q[7] ^ lfsr_h_q[5] ^ lfsr_h_q[4] ^ lfsr_h_q[3]};
    lfsr_v_d = {lfsr_v_q[5:0], lfsr_v_q[6] ^ lfsr_v_q[5]};
    if (lfsr_h_q == '0) lfsr_h_d = SEED_H;
    if (lfsr_v_q == '0) lfsr_v_d = SEED_V;
  end

  // Candidate acceptance test and single-subtraction wrapped fallback position
  always_comb begin
    rise     = TARGET_REACHED & ~reached_q;
    accept   = ({1'b0, lfsr_h_q} <= MAX_H9) && ({1'b0, lfsr_v_q} <= MAX_V8) &&
               ((lfsr_h_q != addr_h_q) || (lfsr_v_q != addr_v_q));
    fb_h_sum = {1'b0, addr_h_q} + 9'd37;
    fb_v_sum = {1'b0, addr_v_q} + 8'd23;
    fb_h     = 8'((fb_h_sum >= LIM_H) ? fb_h_sum - LIM_H : fb_h_sum);
    fb_v     = 7'((fb_v_sum >= LIM_V) ? fb_v_sum - LIM_V : fb_v_sum);
  end

  // Search FSM: IDLE forces the initial target, WIN/LOST freeze, PLAY runs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_h_d = addr_h_q;
    addr_v_d = addr_v_q;
    valid_d  = valid_q;
    upd_d    = 1'b0;
    if (MSM_STATE == MSM_IDLE) begin
      state_d  = HOLD;
      cnt_d    = '0;
      addr_h_d = INIT_H;
      addr_v_d = INIT_V;
      valid_d  = 1'b1;
    end else if (MSM_STATE == MSM_PLAY) begin
      unique case (state_q)
        HOLD: begin
          if (rise) begin
            state_d = SEARCH;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end
        SEARCH: begin
          if (accept) begin
            addr_h_d = lfsr_h_q;
            addr_v_d = lfsr_v_q;
            valid_d  = 1'b1;
            upd_d    = 1'b1;
            state_d  = HOLD;
          end else if (cnt_q == CNT_MAX) begin
            addr_h_d = fb_h;
            addr_v_d = fb_v;
            valid_d  = 1'b1;
            upd_d    = 1'b1;
            state_d  = HOLD;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        default: state_d = HOLD;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= HOLD;
      lfsr_h_q  <= SEED_H;
      lfsr_v_q  <= SEED_V;
      reached_q <= 1'b0;
      cnt_q     <= '0;
      addr_h_q  <= INIT_H;
      addr_v_q  <= INIT_V;
      valid_q   <= 1'b1;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_h_q  <= lfsr_h_d;
      lfsr_v_q  <= lfsr_v_d;
      reached_q <= TARGET_REACHED;
      cnt_q     <= cnt_d;
      addr_h_q  <= addr_h_d;
      addr_v_q  <= addr_v_d;
      valid_q   <= valid_d;
      upd_q     <= upd_d;
    end
  end

  assign TARGET_ADDR_H  = addr_h_q;
  assign TARGET_ADDR_V  = addr_v_q;
  assign TARGET_VALID   = valid_q;
  assign TARGET_UPDATED = upd_q;

endmodule
